tlk2711_axi_slave_mem: RTL and testbench
========================================

TLK2711_AXI_SLAVE_MEM -- requirements
Module: tlk2711_axi_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 48, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width; byte lanes = DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_DEPTH, default 512, number of DATA_WIDTH words, power of two.
REQ-004 SHALL have ports, in order:
  clk  in  1  single clock;
  rst_n  in  1  asynchronous active-low reset;
  s_axi_arvalid/arready  in/out  1  read-address handshake;
  s_axi_arid  in  4;  s_axi_araddr  in  ADDR_WIDTH;  s_axi_arlen  in  8;  s_axi_arsize  in  3;  s_axi_arburst  in  2;
  s_axi_rdata  out  DATA_WIDTH;  s_axi_rid  out  4;  s_axi_rresp  out  2;  s_axi_rlast  out  1;  s_axi_rvalid  out  1;  s_axi_rready  in  1;
  s_axi_awvalid/awready  in/out  1;  s_axi_awid  in  4;  s_axi_awaddr  in  ADDR_WIDTH;  s_axi_awlen  in  8;  s_axi_awsize  in  3;  s_axi_awburst  in  2;
  s_axi_wdata  in  DATA_WIDTH;  s_axi_wstrb  in  DATA_WIDTH/8;  s_axi_wlast/wvalid  in  1;  s_axi_wready  out  1;
  s_axi_bid  out  4;  s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1;
  o_err_cnt  out  16  saturating protocol-error count.
REQ-005 SHALL ignore arprot/arcache/aruser/awprot/awcache/awuser (not ported).

Function
REQ-006 SHALL respond to the tlk2711_dma master as an AXI4 memory slave, one transaction at a time.
REQ-007 FSM states: IDLE, RD_BURST, WR_DATA, WR_RESP.
REQ-008 IDLE: arready/awready asserted combinationally only for the granted channel; at most one AR or AW handshake per cycle.
REQ-009 Simultaneous arvalid and awvalid in IDLE: round-robin grant; write wins the first contest after reset, then alternates.
REQ-010 AR handshake -> RD_BURST; AW handshake -> WR_DATA; captured id/addr/len/size/burst held for the burst.
REQ-011 Word index = addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]; upper address bits ignored; index wraps modulo MEM_DEPTH.
REQ-012 burst 2'b01 (INCR): index +1 per beat; 2'b00 (FIXED): index constant.
REQ-013 burst 2'b10/2'b11 or size != log2(DATA_WIDTH/8): burst executes its full beat count, but writes are suppressed, rdata = 0, resp = SLVERR (2'b10), o_err_cnt += 1.
REQ-014 Read: first rvalid no earlier than 2 cycles after AR handshake; exactly arlen+1 beats; rlast on final beat only; rid = captured arid; rresp OKAY unless REQ-013.
REQ-015 rvalid, rdata, rlast, rid, rresp SHALL stay stable while rvalid && !rready.
REQ-016 Final R handshake -> IDLE.
REQ-017 WR_DATA: wready = 1; each beat writes byte lanes where wstrb bit = 1; lanes with strobe 0 are unchanged.
REQ-018 Beat with wlast handshaked -> WR_RESP.
REQ-019 If the beat count at wlast != awlen+1, or awlen+1 beats arrive without wlast: bresp = SLVERR, o_err_cnt += 1.
REQ-020 In the missing-wlast case, WR_DATA SHALL keep accepting beats without writing them until wlast.
REQ-021 WR_RESP: bvalid = 1 with bid = awid; bvalid/bid/bresp held until bready; handshake -> IDLE.
REQ-022 o_err_cnt SHALL saturate at 16'hFFFF.
REQ-023 Memory contents are not reset.

Reset
REQ-024 rst_n low asynchronously forces IDLE with arready, awready, rvalid, rlast, wready, bvalid = 0.
REQ-025 Reset SHALL clear rdata, rid, rresp, bid, bresp and o_err_cnt to 0 and set round-robin priority to write.
REQ-026 Reset mid-burst abandons the burst; no further beats or responses are issued after release.
REQ-027 Reset deassertion is synchronised internally (two flops) before the FSM leaves IDLE.

Structure
REQ-028 AXI resp encodings (OKAY 2'b00, SLVERR 2'b10), burst encodings and FSM state typedef SHALL live in shared package tlk2711_pkg.
REQ-029 One sub-module, tlk2711_bram_sp: single-port byte-write RAM with 1-cycle registered read, shared by both channels.

Verification
REQ-030 AW addr 0x100, len 3, INCR, wstrb 0xFF, data 1..4; then AR same -> bresp OKAY, bid = awid; rdata 1,2,3,4; rlast on beat 4.
REQ-031 arvalid and awvalid rise in the same cycle twice in a row -> write granted first, read second.
REQ-032 Random rready gaps during an 8-beat read -> R payload unchanged during stalls, no beat lost or duplicated.
REQ-033 Write with wstrb 0x0F over 0xFFFF_FFFF_FFFF_FFFF using data 0 -> read returns 0xFFFF_FFFF_0000_0000.
REQ-034 AR burst 2'b10, len 1 -> 2 beats, rdata 0, rresp SLVERR, o_err_cnt = 1; AW len 3 with wlast on beat 2 -> bresp SLVERR, o_err_cnt = 2.
REQ-035 rst_n low during beat 3 of an 8-beat read -> rvalid = 0 immediately, FSM in IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 AXI slave memory: AXI response and burst
// encodings, the slave FSM state type and a burst legality helper.
package tlk2711_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_DATA  = 2'd2,
        ST_WR_RESP  = 2'd3
    } state_e;

    // A burst is serviced normally only for FIXED/INCR at the full bus width.
    function automatic logic burst_ok(input logic [1:0] burst,
                                      input logic [2:0] size,
                                      input logic [2:0] full_size);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == full_size);
    endfunction

endpackage

// File: rtl/tlk2711_bram_sp.sv
// Single-port RAM with per-byte write enables and a one-cycle registered read.
module tlk2711_bram_sp #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read port: capture the addressed word whenever the RAM is enabled.
    always_comb begin
        rdata_d = en ? mem_q[addr] : rdata_q;
    end

    // NOTE: storage has no reset so it maps onto block RAM; contents survive rst_n.
    // Byte-lane writes and the registered read output.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (we[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tlk2711_axi_slave_mem.sv
// AXI4 memory slave serving the tlk2711_dma master, one transaction at a time.
// Illegal bursts run to completion with SLVERR; protocol errors are counted.
module tlk2711_axi_slave_mem
    import tlk2711_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_DEPTH  = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [3:0]              s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [3:0]              s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [3:0]              s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [3:0]              s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [15:0]             o_err_cnt
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned LANE_W    = $clog2(STRB_W);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [2:0]  FULL_SIZE = 3'(LANE_W);

    state_e                state_d, state_q;
    logic [1:0]            rst_sync_d, rst_sync_q;
    logic                  prio_wr_d, prio_wr_q;
    logic [3:0]            id_d, id_q;
    logic [IDX_W-1:0]      idx_d, idx_q;
    logic [7:0]            len_d, len_q;
    logic                  fixed_d, fixed_q;
    logic                  bad_d, bad_q;
    logic [8:0]            beat_d, beat_q;
    logic                  rd_pend_d, rd_pend_q;
    logic                  rvalid_d, rvalid_q;
    logic                  rlast_d, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
    logic [1:0]            rresp_d, rresp_q;
    logic [1:0]            bresp_d, bresp_q;
    logic [15:0]           err_cnt_d, err_cnt_q;

    logic                  run;
    logic                  grant_wr, grant_rd;
    logic                  err_inc;
    logic                  ram_en;
    logic [STRB_W-1:0]     ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Only the word-index slice of each address is decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_araddr, s_axi_awaddr};

    assign run      = rst_sync_q[1];
    assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || prio_wr_q);
    assign grant_rd = s_axi_arvalid && !grant_wr;

    tlk2711_bram_sp #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (MEM_DEPTH)
    ) u_bram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (idx_q),
        .wdata(s_axi_wdata),
        .rdata(ram_rdata)
    );

    // Next-state, datapath and handshake outputs for the single-transaction FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d       = state_q;
        rst_sync_d    = {rst_sync_q[0], 1'b1};
        prio_wr_d     = prio_wr_q;
        id_d          = id_q;
        idx_d         = idx_q;
        len_d         = len_q;
        fixed_d       = fixed_q;
        bad_d         = bad_q;
        beat_d        = beat_q;
        rd_pend_d     = rd_pend_q;
        rvalid_d      = rvalid_q;
        rlast_d       = rlast_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        bresp_d       = bresp_q;
        err_inc       = 1'b0;
        ram_en        = 1'b0;
        ram_we        = '0;
        s_axi_arready = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    s_axi_awready = grant_wr;
                    s_axi_arready = grant_rd;
                    if (s_axi_awvalid && s_axi_arvalid) prio_wr_d = !prio_wr_q;
                    if (grant_wr) begin
                        id_d    = s_axi_awid;
                        idx_d   = s_axi_awaddr[LANE_W +: IDX_W];
                        len_d   = s_axi_awlen;
                        fixed_d = (s_axi_awburst == BURST_FIXED);
                        bad_d   = !burst_ok(s_axi_awburst, s_axi_awsize, FULL_SIZE);
                        beat_d  = '0;
                        state_d = ST_WR_DATA;
                    end else if (grant_rd) begin
                        id_d      = s_axi_arid;
                        idx_d     = s_axi_araddr[LANE_W +: IDX_W];
                        len_d     = s_axi_arlen;
                        fixed_d   = (s_axi_arburst == BURST_FIXED);
                        bad_d     = !burst_ok(s_axi_arburst, s_axi_arsize, FULL_SIZE);
                        err_inc   = !burst_ok(s_axi_arburst, s_axi_arsize, FULL_SIZE);
                        rresp_d   = burst_ok(s_axi_arburst, s_axi_arsize, FULL_SIZE)
                                    ? RESP_OKAY : RESP_SLVERR;
                        beat_d    = '0;
                        rd_pend_d = 1'b0;
                        state_d   = ST_RD_BURST;
                    end
                end
            end

            ST_RD_BURST: begin
                if (rvalid_q) begin
                    // Payload registers only move after the beat is taken.
                    if (s_axi_rready) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        if (rlast_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            beat_d = beat_q + 9'd1;
                            idx_d  = fixed_q ? idx_q : idx_q + 1'b1;
                        end
                    end
                end else if (rd_pend_q) begin
                    rd_pend_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = bad_q ? '0 : ram_rdata;
                    rlast_d   = (beat_q == {1'b0, len_q});
                end else begin
                    ram_en    = 1'b1;
                    rd_pend_d = 1'b1;
                end
            end

            ST_WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    // Beats past awlen+1 are drained but never written.
                    if (!bad_q && (beat_q <= {1'b0, len_q})) begin
                        ram_en = 1'b1;
                        ram_we = s_axi_wstrb;
                    end
                    if (beat_q != 9'h1FF) beat_d = beat_q + 9'd1;
                    idx_d = fixed_q ? idx_q : idx_q + 1'b1;
                    if (s_axi_wlast) begin
                        state_d = ST_WR_RESP;
                        if (bad_q || (beat_q != {1'b0, len_q})) begin
                            bresp_d = RESP_SLVERR;
                            err_inc = 1'b1;
                        end else begin
                            bresp_d = RESP_OKAY;
                        end
                    end
                end
            end

            ST_WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        err_cnt_d = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // State registers; the two-flop synchroniser holds the FSM in IDLE after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rst_sync_q <= 2'b00;
            prio_wr_q  <= 1'b1;
            id_q       <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            fixed_q    <= 1'b0;
            bad_q      <= 1'b0;
            beat_q     <= '0;
            rd_pend_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            bresp_q    <= RESP_OKAY;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rst_sync_q <= rst_sync_d;
            prio_wr_q  <= prio_wr_d;
            id_q       <= id_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            fixed_q    <= fixed_d;
            bad_q      <= bad_d;
            beat_q     <= beat_d;
            rd_pend_q  <= rd_pend_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign s_axi_rdata  = rdata_q;
    assign s_axi_rid    = id_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rlast_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_bid    = id_q;
    assign s_axi_bresp  = bresp_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tlk2711_axi_slave_mem.sv
// Directed bench for tlk2711_axi_slave_mem: write/read round trips, arbitration,
// byte strobes, stalled reads, error bursts and mid-burst reset.
module tb_tlk2711_axi_slave_mem;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [63:0] BASE  = 64'h0123_4567_89AB_CD00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_arid;
    logic [47:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic [63:0] s_axi_rdata;
    logic [3:0]  s_axi_rid;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        s_axi_awvalid, s_axi_awready;
    logic [3:0]  s_axi_awid;
    logic [47:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [15:0] o_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tlk2711_axi_slave_mem dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .o_err_cnt(o_err_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arsize = size;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awburst = burst; s_axi_awsize = size;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        @(negedge clk);
        set_aw(id, addr, len, burst, size);
        s_axi_awvalid = 1'b1;
        #1;
        while (!s_axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        check("aw_ready", s_axi_awready, 1'b1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        @(negedge clk);
        set_ar(id, addr, len, burst, size);
        s_axi_arvalid = 1'b1;
        #1;
        while (!s_axi_arready && n < 50) begin @(negedge clk); #1; n++; end
        check("ar_ready", s_axi_arready, 1'b1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        @(negedge clk);
        s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last;
        #1;
        while (!s_axi_wready && n < 50) begin @(negedge clk); #1; n++; end
        check("w_ready", s_axi_wready, 1'b1);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic do_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
        int n = 0;
        @(negedge clk);
        s_axi_bready = 1'b1;
        #1;
        while (!s_axi_bvalid && n < 50) begin @(negedge clk); #1; n++; end
        check({tag, "_bvalid"}, s_axi_bvalid, 1'b1);
        check({tag, "_bid"}, s_axi_bid, exp_id);
        check({tag, "_bresp"}, s_axi_bresp, exp_resp);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    // Waits for a beat, optionally holds rready low for 'stall' cycles while
    // checking the payload is frozen, then takes it and checks it.
    task automatic rd_beat(input string tag, input logic [63:0] exp_data, input logic exp_last,
                           input logic [1:0] exp_resp, input logic [3:0] exp_id, input int stall);
        int n = 0;
        logic [70:0] snap;
        @(negedge clk); #1;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); #1; n++; end
        check({tag, "_rvalid"}, s_axi_rvalid, 1'b1);
        snap = {s_axi_rdata, s_axi_rlast, s_axi_rresp, s_axi_rid};
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            check({tag, "_stall"}, {s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rresp, s_axi_rid},
                  {1'b1, snap});
        end
        s_axi_rready = 1'b1;
        check({tag, "_rdata"}, s_axi_rdata, exp_data);
        check({tag, "_rlast"}, s_axi_rlast, exp_last);
        check({tag, "_rresp"}, s_axi_rresp, exp_resp);
        check({tag, "_rid"}, s_axi_rid, exp_id);
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalls [8] = '{0, 2, 1, 3, 0, 1, 2, 0};
        int seen;
        int n;

        rst_n = 1'b0;
        s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
        set_ar(0, 0, 0, INCR, 3'd3);
        set_aw(0, 0, 0, INCR, 3'd3);
        s_axi_rready = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_bready = 1'b0;

        // Reset state with both address valids pushing.
        repeat (3) @(negedge clk);
        #1;
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_rvalid", s_axi_rvalid, 1'b0);
        check("rst_rlast", s_axi_rlast, 1'b0);
        check("rst_wready", s_axi_wready, 1'b0);
        check("rst_bvalid", s_axi_bvalid, 1'b0);
        check("rst_payload", {s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_bid, s_axi_bresp}, '0);
        check("rst_err_cnt", o_err_cnt, 16'd0);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;

        // First contest right at reset release: synchroniser delay, then write wins.
        @(negedge clk);
        rst_n = 1'b1;
        set_aw(4'd3, 48'h100, 8'd3, INCR, 3'd3);
        set_ar(4'd9, 48'h100, 8'd3, INCR, 3'd3);
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        #1;
        check("sync_hold0", {s_axi_awready, s_axi_arready}, 2'b00);
        @(negedge clk); #1;
        check("sync_hold1", {s_axi_awready, s_axi_arready}, 2'b00);
        @(negedge clk); #1;
        check("contest1_grant", {s_axi_awready, s_axi_arready}, 2'b10);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        @(negedge clk); #1;
        check("ar_blocked_in_wr", s_axi_arready, 1'b0);
        for (int i = 0; i < 4; i++) w_beat(64'(i + 1), 8'hFF, i == 3);
        do_b("wr_0x100", 4'd3, OKAY);
        do_ar(4'd9, 48'h100, 8'd3, INCR, 3'd3);
        for (int i = 0; i < 4; i++) rd_beat("rd_0x100", 64'(i + 1), i == 3, OKAY, 4'd9, 0);

        // Second contest: read wins this time.
        @(negedge clk);
        set_aw(4'd1, 48'h200, 8'd0, INCR, 3'd3);
        set_ar(4'd2, 48'h100, 8'd0, INCR, 3'd3);
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        #1;
        check("contest2_grant", {s_axi_awready, s_axi_arready}, 2'b01);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        rd_beat("rd_contest2", 64'd1, 1'b1, OKAY, 4'd2, 0);
        do_aw(4'd1, 48'h200, 8'd0, INCR, 3'd3);
        w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        do_b("wr_ones", 4'd1, OKAY);

        // Partial strobe over all-ones.
        do_aw(4'd7, 48'h200, 8'd0, INCR, 3'd3);
        w_beat(64'd0, 8'h0F, 1'b1);
        do_b("wr_strb", 4'd7, OKAY);
        do_ar(4'd8, 48'h200, 8'd0, INCR, 3'd3);
        rd_beat("rd_strb", 64'hFFFF_FFFF_0000_0000, 1'b1, OKAY, 4'd8, 0);

        // FIXED burst rewrites one word; upper address bits are ignored on readback.
        do_aw(4'd2, 48'h300, 8'd1, FIXED, 3'd3);
        w_beat(64'hA, 8'hFF, 1'b0);
        w_beat(64'hB, 8'hFF, 1'b1);
        do_b("wr_fixed", 4'd2, OKAY);
        do_ar(4'd2, 48'hABCD_0000_1300, 8'd0, INCR, 3'd3);
        rd_beat("rd_fixed", 64'hB, 1'b1, OKAY, 4'd2, 0);

        // 8-beat write, then read back with rready stalls.
        do_aw(4'd4, 48'h400, 8'd7, INCR, 3'd3);
        for (int i = 0; i < 8; i++) w_beat(BASE + 64'(i), 8'hFF, i == 7);
        do_b("wr_8beat", 4'd4, OKAY);
        do_ar(4'd5, 48'h400, 8'd7, INCR, 3'd3);
        for (int i = 0; i < 8; i++) rd_beat("rd_8beat", BASE + 64'(i), i == 7, OKAY, 4'd5, stalls[i]);

        // Illegal read burst type.
        do_ar(4'd6, 48'h100, 8'd1, 2'b10, 3'd3);
        rd_beat("rd_wrap0", 64'd0, 1'b0, SLVERR, 4'd6, 0);
        rd_beat("rd_wrap1", 64'd0, 1'b1, SLVERR, 4'd6, 0);
        check("err_cnt_1", o_err_cnt, 16'd1);

        // Early wlast.
        do_aw(4'd7, 48'h500, 8'd3, INCR, 3'd3);
        w_beat(64'h11, 8'hFF, 1'b0);
        w_beat(64'h22, 8'hFF, 1'b1);
        do_b("wr_early_wlast", 4'd7, SLVERR);
        check("err_cnt_2", o_err_cnt, 16'd2);

        // Missing wlast: the extra beat is drained without a write.
        do_aw(4'd8, 48'h600, 8'd0, INCR, 3'd3);
        w_beat(64'h66, 8'hFF, 1'b0);
        w_beat(64'h77, 8'hFF, 1'b1);
        do_b("wr_late_wlast", 4'd8, SLVERR);
        check("err_cnt_3", o_err_cnt, 16'd3);
        do_ar(4'd8, 48'h600, 8'd0, INCR, 3'd3);
        rd_beat("rd_late_wlast", 64'h66, 1'b1, OKAY, 4'd8, 0);

        // Narrow read size.
        do_ar(4'd9, 48'h100, 8'd0, INCR, 3'd2);
        rd_beat("rd_narrow", 64'd0, 1'b1, SLVERR, 4'd9, 0);
        check("err_cnt_4", o_err_cnt, 16'd4);

        // Reset while beat 3 of an 8-beat read is presented.
        do_ar(4'd10, 48'h400, 8'd7, INCR, 3'd3);
        rd_beat("rd_pre_rst0", BASE, 1'b0, OKAY, 4'd10, 0);
        rd_beat("rd_pre_rst1", BASE + 64'd1, 1'b0, OKAY, 4'd10, 0);
        n = 0;
        @(negedge clk); #1;
        while (!s_axi_rvalid && n < 50) begin @(negedge clk); #1; n++; end
        check("beat3_rvalid", s_axi_rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", s_axi_rvalid, 1'b0);
        check("midrst_ready", {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid}, 4'b0000);
        check("midrst_err_cnt", o_err_cnt, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_axi_rready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (s_axi_rvalid) seen++;
        end
        s_axi_rready = 1'b0;
        check("no_beats_after_rst", seen, 0);
        do_ar(4'd11, 48'h400, 8'd1, INCR, 3'd3);
        rd_beat("rd_post_rst0", BASE, 1'b0, OKAY, 4'd11, 0);
        rd_beat("rd_post_rst1", BASE + 64'd1, 1'b1, OKAY, 4'd11, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
